demo_sequencer: RTL and testbench
=================================

Name: demo_sequencer

Overview:
Frame-level controller for the VGA demo effect datapath. Detects frame boundaries from the vsync output of the sync generator inside the clk domain, maintains the effect frame counter, and derives the scene/mode selects consumed by the pixel pipeline. Supports pause, single-step, speed division, and a scene skip with fade-out/fade-in sequencing. All outputs are glitch-free at frame granularity.

Parameters:
FRAME_W, 12, frame counter width
RESET_FRAME, 300, frame counter value loaded on reset

Ports:
clk  in  1  pixel clock (25.175 MHz)
reset  in  1  synchronous active-high reset
vsync  in  1  registered vsync from sync generator, active high
pause  in  1  level; freeze frame counter while high
step  in  1  one-cycle pulse; advance one frame while paused
skip  in  1  one-cycle pulse; fade to start of next scene
speed  in  2  advance once every 2^speed frames
frame_tick  out  1  one-cycle pulse, outputs just updated
frame_counter  out  FRAME_W  effect frame count
phase  out  7  frame_counter[6:0]
scene  out  2  frame_counter[8:7]
zoom_mode  out  1  frame_counter[7] & frame_counter[8]
mode_a  out  1  frame_counter[8]
mode_b  out  1  frame_counter[7] ^ frame_counter[8]
fade  out  2  brightness; 3 = full, 0 = black

Behaviour:
- Reset (sync, active-high, wins over everything, legal mid-fade): frame_counter=RESET_FRAME, fade=3, state=RUN, div=0, skip_pend=0, step_pend=0, frame_tick=0, vsync_d=1. vsync_d=1 suppresses a spurious tick when vsync is high at reset release.
- tick = vsync & ~vsync_d (vsync_d registered every cycle). All state updates occur on the clk edge where tick=1; frame_tick=1 for exactly the following cycle. Outputs never change on non-tick cycles.
- phase/scene/zoom_mode/mode_a/mode_b are pure decodes of the registered frame_counter.
- Divider: 3-bit div increments on every tick (wraps mod 8). mask=(1<<speed)-1; adv = tick & ((div & mask)==mask). speed=0 gives every tick. A speed change takes effect on the next tick without a reset of div.
- skip_pend sets on skip in RUN or PAUSED and is ignored in FADE_OUT/FADE_IN. step_pend sets on step in PAUSED only. Both clear when consumed.
- States and tick actions:
  - RUN: skip_pend -> FADE_OUT, fade<=2, counter +1 if adv. Else if pause -> PAUSED, counter held. Else counter +1 if adv. skip has priority over pause.
  - PAUSED: skip_pend -> as from RUN, counter +1 if adv. Else if step_pend -> counter +1 regardless of adv, stay. Else if !pause -> RUN, counter held. Else hold.
  - FADE_OUT: fade>0 -> fade<=fade-1, counter +1 if adv. fade==0 -> counter<=(counter | 7'h7F)+1, fade=0, FADE_IN. This jump is the start of the next scene with natural carry, overrides adv, and counter wraps at 2^FRAME_W.
  - FADE_IN: fade<=fade+1, counter +1 if adv. The tick that sets fade=3 also enters RUN.
- Skip sequence at speed=0, from the entry tick: fade 2,1,0, jump(0), 1, 2, 3/RUN = 7 ticks.
- pause/step during fades are not acted on. pause is re-sampled on the first RUN tick.
- Counter increment wraps 4095->0.

Test Plan:
- Reset with vsync low, release, 3 vsync rising edges at speed=0 -> frame_counter 300->303; scene=2, mode_a=1, mode_b=1, zoom_mode=0, fade=3; frame_tick one cycle per edge.
- speed=2, 8 vsync edges from reset -> counter advances only on ticks 4 and 8 (302). Change to speed=0 mid-run -> advances every subsequent tick.
- pause high at counter 310 -> held for 5 ticks. Step pulse -> 311 on next tick. Two steps before one tick -> single increment. pause low -> resumes 312 on the following adv tick.
- skip at counter 300, speed=0 -> per tick (counter, fade): (301,2), (302,1), (303,0), (384,0), (385,1), (386,2), (387,3) in RUN. scene=3, zoom_mode=1, mode_b=0 after jump. Skip pulses during fade ignored.
- Counter 4095 with speed=0 -> next tick 0. skip from 4095 -> jump lands at 0, scene=0.
- vsync held high across reset release -> no frame_tick until vsync falls and rises. Reset asserted in FADE_OUT -> next cycle counter=300, fade=3, RUN.

Source files
------------

// File: rtl/demo_sequencer.sv
// Frame-level sequencer for the demo effect: counts frames on vsync rising edges,
// applies pause/step/speed control and runs the scene-skip fade sequence.
module demo_sequencer #(
  parameter int unsigned FRAME_W     = 12,
  parameter int unsigned RESET_FRAME = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               pause,
  input  logic               step,
  input  logic               skip,
  input  logic [1:0]         speed,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_counter,
  output logic [6:0]         phase,
  output logic [1:0]         scene,
  output logic               zoom_mode,
  output logic               mode_a,
  output logic               mode_b,
  output logic [1:0]         fade
);

  typedef enum logic [1:0] {StRun, StPaused, StFadeOut, StFadeIn} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic [1:0]         fade_q, fade_d;
  logic [2:0]         div_q;
  logic               vsync_q;
  logic               skip_pend_q, skip_pend_d;
  logic               step_pend_q, step_pend_d;
  logic               frame_tick_q;

  logic               tick;
  logic               adv;
  logic [2:0]         mask;
  logic [FRAME_W-1:0] cnt_inc;
  logic [FRAME_W-1:0] cnt_jump;
  logic               skip_taken;
  logic               step_taken;

  assign tick     = vsync & ~vsync_q;
  assign cnt_inc  = cnt_q + FRAME_W'(1);
  // Start of the next 128-frame scene; the carry wraps naturally at 2^FRAME_W.
  assign cnt_jump = (cnt_q | FRAME_W'(7'h7F)) + FRAME_W'(1);

  // Divider mask: advance when the low 'speed' bits of div are all ones.
  always_comb begin
    mask = 3'b000;
    unique case (speed)
      2'd0: mask = 3'b000;
      2'd1: mask = 3'b001;
      2'd2: mask = 3'b011;
      2'd3: mask = 3'b111;
      default: mask = 3'b000;
    endcase
  end

  assign adv = tick & ((div_q & mask) == mask);

  // Next-state logic: everything moves only on a frame tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fade_d     = fade_q;
    skip_taken = 1'b0;
    step_taken = 1'b0;
    if (tick) begin
      case (state_q)
        StRun: begin
          if (skip_pend_q) begin
            state_d    = StFadeOut;
            fade_d     = 2'd2;
            skip_taken = 1'b1;
            if (adv) cnt_d = cnt_inc;
          end else if (pause) begin
            state_d = StPaused;
          end else if (adv) begin
            cnt_d = cnt_inc;
          end
        end
        StPaused: begin
          if (skip_pend_q) begin
            state_d    = StFadeOut;
            fade_d     = 2'd2;
            skip_taken = 1'b1;
            if (adv) cnt_d = cnt_inc;
          end else if (step_pend_q) begin
            // A step ignores the speed divider.
            cnt_d      = cnt_inc;
            step_taken = 1'b1;
          end else if (!pause) begin
            state_d = StRun;
          end
        end
        StFadeOut: begin
          if (fade_q != 2'd0) begin
            fade_d = fade_q - 2'd1;
            if (adv) cnt_d = cnt_inc;
          end else begin
            cnt_d   = cnt_jump;
            state_d = StFadeIn;
          end
        end
        StFadeIn: begin
          fade_d = fade_q + 2'd1;
          if (adv) cnt_d = cnt_inc;
          if (fade_q == 2'd2) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Pending requests: captured only while not fading, dropped once consumed.
  always_comb begin
    skip_pend_d = skip_pend_q;
    step_pend_d = step_pend_q;
    if (skip_taken) begin
      skip_pend_d = 1'b0;
    end else if (skip && (state_q == StRun || state_q == StPaused)) begin
      skip_pend_d = 1'b1;
    end
    // A step is only meaningful while paused, so leaving PAUSED discards it.
    if (step_taken || (tick && state_q == StPaused && state_d != StPaused)) begin
      step_pend_d = 1'b0;
    end else if (step && state_q == StPaused) begin
      step_pend_d = 1'b1;
    end
  end

  // State registers; vsync_q resets high so a vsync already high at release is not a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      cnt_q        <= FRAME_W'(RESET_FRAME);
      fade_q       <= 2'd3;
      div_q        <= 3'd0;
      vsync_q      <= 1'b1;
      skip_pend_q  <= 1'b0;
      step_pend_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fade_q       <= fade_d;
      vsync_q      <= vsync;
      skip_pend_q  <= skip_pend_d;
      step_pend_q  <= step_pend_d;
      frame_tick_q <= tick;
      if (tick) div_q <= div_q + 3'd1;
    end
  end

  assign frame_tick    = frame_tick_q;
  assign frame_counter = cnt_q;
  assign fade          = fade_q;
  assign phase         = cnt_q[6:0];
  assign scene         = cnt_q[8:7];
  assign zoom_mode     = cnt_q[7] & cnt_q[8];
  assign mode_a        = cnt_q[8];
  assign mode_b        = cnt_q[7] ^ cnt_q[8];

endmodule

// File: tb/tb_demo_sequencer.sv
// Self-checking bench for demo_sequencer: directed scenarios plus randomized frames,
// all compared against a frame-level reference model.
module tb_demo_sequencer;

  localparam int unsigned FrameW     = 12;
  localparam int unsigned ResetFrame = 300;
  localparam int          Wrap       = 1 << FrameW;

  logic              clk = 1'b0;
  logic              reset;
  logic              vsync;
  logic              pause;
  logic              step;
  logic              skip;
  logic [1:0]        speed;
  logic              frame_tick;
  logic [FrameW-1:0] frame_counter;
  logic [6:0]        phase;
  logic [1:0]        scene;
  logic              zoom_mode;
  logic              mode_a;
  logic              mode_b;
  logic [1:0]        fade;

  demo_sequencer #(
    .FRAME_W    (FrameW),
    .RESET_FRAME(ResetFrame)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .pause        (pause),
    .step         (step),
    .skip         (skip),
    .speed        (speed),
    .frame_tick   (frame_tick),
    .frame_counter(frame_counter),
    .phase        (phase),
    .scene        (scene),
    .zoom_mode    (zoom_mode),
    .mode_a       (mode_a),
    .mode_b       (mode_b),
    .fade         (fade)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept at frame granularity.
  int m_cnt;
  int m_fade;
  int m_ticks;
  bit m_paused;
  bit m_skip_pend;
  bit m_step_pend;
  int m_fade_q[$];  // remaining fade levels of a skip; -1 marks the scene jump

  int exp_cnt[7]  = '{301, 302, 303, 384, 385, 386, 387};
  int exp_fade[7] = '{2, 1, 0, 0, 1, 2, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt       = ResetFrame;
    m_fade      = 3;
    m_ticks     = 0;
    m_paused    = 1'b0;
    m_skip_pend = 1'b0;
    m_step_pend = 1'b0;
    m_fade_q.delete();
  endfunction

  function automatic void model_tick();
    int period = 1 << speed;
    bit adv    = (m_ticks % period) == (period - 1);
    int item;
    m_ticks++;
    if (m_fade_q.size() != 0) begin
      item = m_fade_q.pop_front();
      if (item < 0) begin
        m_cnt  = (((m_cnt / 128) + 1) * 128) % Wrap;
        m_fade = 0;
      end else begin
        m_fade = item;
        if (adv) m_cnt = (m_cnt + 1) % Wrap;
      end
    end else if (m_skip_pend) begin
      m_skip_pend = 1'b0;
      m_step_pend = 1'b0;
      m_paused    = 1'b0;
      m_fade      = 2;
      m_fade_q    = '{1, 0, -1, 1, 2, 3};
      if (adv) m_cnt = (m_cnt + 1) % Wrap;
    end else if (!m_paused) begin
      if (pause) m_paused = 1'b1;
      else if (adv) m_cnt = (m_cnt + 1) % Wrap;
    end else if (m_step_pend) begin
      m_step_pend = 1'b0;
      m_cnt       = (m_cnt + 1) % Wrap;
    end else if (!pause) begin
      m_paused = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    int sc = (m_cnt / 128) % 4;
    check_eq({tag, ".cnt"}, 32'(frame_counter), 32'(m_cnt));
    check_eq({tag, ".phase"}, 32'(phase), 32'(m_cnt % 128));
    check_eq({tag, ".scene"}, 32'(scene), 32'(sc));
    check_eq({tag, ".zoom"}, 32'(zoom_mode), 32'(sc == 3));
    check_eq({tag, ".mode_a"}, 32'(mode_a), 32'(sc >= 2));
    check_eq({tag, ".mode_b"}, 32'(mode_b), 32'(sc == 1 || sc == 2));
    check_eq({tag, ".fade"}, 32'(fade), 32'(m_fade));
  endtask

  task automatic do_reset(input logic vs);
    reset = 1'b1;
    vsync = vs;
    pause = 1'b0;
    step  = 1'b0;
    skip  = 1'b0;
    @(negedge clk);
    check_eq("rst.hold_cnt", 32'(frame_counter), 32'(ResetFrame));
    check_eq("rst.hold_fade", 32'(fade), 3);
    check_eq("rst.hold_tick", 32'(frame_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst.tick", 32'(frame_tick), 0);
    check_outputs("rst");
  endtask

  // One frame: vsync low (pulses land here, never on a tick edge), then a rising edge.
  task automatic frame(input int low_cycles, input bit do_skip, input int n_steps);
    vsync = 1'b0;
    repeat (low_cycles) @(negedge clk);
    if (do_skip) begin
      skip = 1'b1;
      if (m_fade_q.size() == 0) m_skip_pend = 1'b1;
      @(negedge clk);
      skip = 1'b0;
    end
    for (int i = 0; i < n_steps; i++) begin
      step = 1'b1;
      if (m_paused) m_step_pend = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    vsync = 1'b1;
    model_tick();
    @(negedge clk);
    check_eq("frame.tick_hi", 32'(frame_tick), 1);
    check_outputs("frame");
    @(negedge clk);
    check_eq("frame.tick_lo", 32'(frame_tick), 0);
    check_eq("frame.stable", 32'(frame_counter), 32'(m_cnt));
  endtask

  // Fast-forward with whole skip sequences, then single frames (speed 0, not paused).
  task automatic run_to(input int target);
    int guard = 0;
    while (m_cnt != target && guard < 6000) begin
      if (target - m_cnt >= 131) begin
        frame(1, 1'b1, 0);
        repeat (6) frame(1, 1'b0, 0);
      end else begin
        frame(1, 1'b0, 0);
      end
      guard++;
    end
    check_eq("run_to.reach", 32'(frame_counter), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    speed = 2'd0;
    step  = 1'b0;
    skip  = 1'b0;
    pause = 1'b0;
    vsync = 1'b0;
    reset = 1'b1;

    // Basic counting at speed 0.
    do_reset(1'b0);
    repeat (3) frame(2, 1'b0, 0);
    check_eq("basic.cnt", 32'(frame_counter), 303);
    check_eq("basic.scene", 32'(scene), 2);
    check_eq("basic.mode_a", 32'(mode_a), 1);
    check_eq("basic.mode_b", 32'(mode_b), 1);
    check_eq("basic.zoom", 32'(zoom_mode), 0);
    check_eq("basic.fade", 32'(fade), 3);

    // Speed divider, then a mid-run speed change.
    do_reset(1'b0);
    speed = 2'd2;
    repeat (3) frame(1, 1'b0, 0);
    check_eq("speed.t3", 32'(frame_counter), 300);
    frame(1, 1'b0, 0);
    check_eq("speed.t4", 32'(frame_counter), 301);
    repeat (4) frame(1, 1'b0, 0);
    check_eq("speed.t8", 32'(frame_counter), 302);
    speed = 2'd0;
    frame(1, 1'b0, 0);
    check_eq("speed.fast1", 32'(frame_counter), 303);
    frame(1, 1'b0, 0);
    check_eq("speed.fast2", 32'(frame_counter), 304);

    // Pause, step and resume.
    do_reset(1'b0);
    repeat (10) frame(1, 1'b0, 0);
    pause = 1'b1;
    repeat (5) frame(1, 1'b0, 0);
    check_eq("pause.held", 32'(frame_counter), 310);
    frame(1, 1'b0, 1);
    check_eq("pause.step", 32'(frame_counter), 311);
    pause = 1'b0;
    frame(1, 1'b0, 0);
    check_eq("pause.release", 32'(frame_counter), 311);
    frame(1, 1'b0, 0);
    check_eq("pause.resume", 32'(frame_counter), 312);
    pause = 1'b1;
    frame(1, 1'b0, 0);
    frame(1, 1'b0, 2);
    check_eq("pause.dbl_step", 32'(frame_counter), 313);
    frame(1, 1'b0, 0);
    check_eq("pause.dbl_once", 32'(frame_counter), 313);
    pause = 1'b0;

    // Scene skip with extra skip pulses ignored during the fade.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      frame(2, (i == 0) || (i == 1) || (i == 4), 0);
      check_eq("skip.cnt", 32'(frame_counter), 32'(exp_cnt[i]));
      check_eq("skip.fade", 32'(fade), 32'(exp_fade[i]));
      if (i == 3) begin
        check_eq("skip.scene", 32'(scene), 3);
        check_eq("skip.zoom", 32'(zoom_mode), 1);
        check_eq("skip.mode_b", 32'(mode_b), 0);
      end
    end
    frame(1, 1'b0, 0);
    check_eq("skip.after", 32'(frame_counter), 388);
    check_eq("skip.after_fade", 32'(fade), 3);

    // Counter wrap and a scene jump that wraps.
    do_reset(1'b0);
    run_to(4095);
    frame(1, 1'b0, 0);
    check_eq("wrap.inc", 32'(frame_counter), 0);
    run_to(4092);
    frame(1, 1'b1, 0);
    repeat (3) frame(1, 1'b0, 0);
    check_eq("wrap.jump", 32'(frame_counter), 0);
    check_eq("wrap.scene", 32'(scene), 0);
    repeat (3) frame(1, 1'b0, 0);
    check_eq("wrap.fade", 32'(fade), 3);

    // vsync high across reset release gives no tick.
    do_reset(1'b1);
    repeat (3) begin
      @(negedge clk);
      check_eq("vs_hi.no_tick", 32'(frame_tick), 0);
      check_eq("vs_hi.cnt", 32'(frame_counter), 300);
    end
    frame(1, 1'b0, 0);
    check_eq("vs_hi.first", 32'(frame_counter), 301);

    // Reset in the middle of a fade-out returns to a clean RUN.
    frame(1, 1'b1, 0);
    frame(1, 1'b0, 0);
    check_eq("rst_fade.pre", 32'(fade), 1);
    do_reset(1'b1);
    frame(1, 1'b0, 0);
    check_eq("rst_fade.run", 32'(frame_counter), 301);
    check_eq("rst_fade.full", 32'(fade), 3);

    // Randomized frames against the model.
    do_reset(1'b0);
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(7) == 0) pause = ~pause;
      if ($urandom_range(15) == 0) speed = 2'($urandom_range(3));
      frame(int'($urandom_range(4, 1)), $urandom_range(11) == 0,
            ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
